// File: rtl/peripheral_div_gen.sv
// peripheral_div_gen: memory-mapped iterative integer divider (restoring
// algorithm, one quotient bit per clock) for the CPU peripheral bus.
// Register map: 0x04 A (W), 0x08 B (W), 0x0C control (W: bit0 start,
// bit1 signed), 0x10 quotient (R), 0x14 status (R: done, busy, dbz, ovf),
// 0x18 remainder (R). Other addresses read as 0 and ignore writes.
// Optional feature macro: DIV_SIGNED_EN enables two's-complement division
// selected by control bit1; without it the divider is unsigned only.
module peripheral_div_gen #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [WIDTH-1:0]  entrada_datos,
    input  logic              habilitar,
    input  logic [ADDR_W-1:0] direccion,
    input  logic              leer,
    input  logic              escribir,
    output logic [31:0]       salida_datos
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_A      = ADDR_W'(5'h04);
    localparam logic [ADDR_W-1:0] ADDR_B      = ADDR_W'(5'h08);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(5'h0C);
    localparam logic [ADDR_W-1:0] ADDR_QUOT   = ADDR_W'(5'h10);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(5'h14);
    localparam logic [ADDR_W-1:0] ADDR_REM    = ADDR_W'(5'h18);

    // Programmer-visible registers
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_r;
    logic             done;
    logic             dbz;

    // Divider working state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;

    // Bus qualification: a simultaneous read and write is treated as a write only.
    logic wr_en;
    logic rd_en;
    logic busy;
    logic start;

    assign wr_en = habilitar & escribir;
    assign rd_en = habilitar & leer & ~escribir;
    assign busy  = (state != S_IDLE);
    assign start = wr_en && !busy && (direccion == ADDR_CTRL) && entrada_datos[0];

    // Operand magnitudes and result correction. A and B cannot change while
    // busy, so these can be derived combinationally from the stored registers.
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf_bit;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic op_signed;
    logic ovf;
    logic a_neg;
    logic b_neg;
    logic ovf_case;

    assign a_neg    = op_signed & reg_a[WIDTH-1];
    assign b_neg    = op_signed & reg_b[WIDTH-1];
    assign mag_a    = a_neg ? -reg_a : reg_a;
    assign mag_b    = b_neg ? -reg_b : reg_b;
    // Quotient is negative when operand signs differ; remainder follows A.
    assign q_fix    = (a_neg ^ b_neg) ? -quo : quo;
    assign r_fix    = a_neg ? -rem : rem;
    assign ovf_case = op_signed && (reg_a == MIN_NEG) && (reg_b == '1);
    assign ovf_bit  = ovf;
`else
    assign mag_a   = reg_a;
    assign mag_b   = reg_b;
    assign q_fix   = quo;
    assign r_fix   = rem;
    assign ovf_bit = 1'b0;
`endif

    // One restoring step: the trial accumulator is one bit wider than the
    // operands so the shifted-in bit never loses a carry.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    assign trial    = {rem, quo[WIDTH-1]};
    assign diff     = trial - {1'b0, mag_b};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    // Control bits above the defined fields carry no meaning.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^entrada_datos[WIDTH-1:1];

    // Register writes and the divider FSM.
    always_ff @(posedge clock) begin
        if (rst) begin
            reg_a     <= '0;
            reg_b     <= '0;
            reg_q     <= '0;
            reg_r     <= '0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
`ifdef DIV_SIGNED_EN
            op_signed <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (wr_en && !busy) begin
                if (direccion == ADDR_A) reg_a <= entrada_datos;
                if (direccion == ADDR_B) reg_b <= entrada_datos;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        done      <= 1'b0;
                        dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
                        ovf       <= 1'b0;
                        op_signed <= entrada_datos[1];
`endif
                    end
                end
                S_LOAD: begin
                    rem <= '0;
                    quo <= mag_a;
                    cnt <= CNT_W'(WIDTH - 1);
                    if (mag_b == '0) begin
                        dbz   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_DONE;
                end
                S_DONE: begin
                    if (dbz) begin
                        reg_q <= '1;
                        reg_r <= reg_a;
                    end else begin
                        reg_q <= q_fix;
                        reg_r <= r_fix;
                    end
`ifdef DIV_SIGNED_EN
                    ovf   <= ovf_case;
`endif
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered read port; the last value read is held until the next read.
    always_ff @(posedge clock) begin
        if (rst) begin
            salida_datos <= '0;
        end else if (rd_en) begin
            case (direccion)
                ADDR_QUOT:   salida_datos <= 32'(reg_q);
                ADDR_STATUS: salida_datos <= {28'd0, ovf_bit, dbz, busy, done};
                ADDR_REM:    salida_datos <= 32'(reg_r);
                default:     salida_datos <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_div_gen.sv
// tb_peripheral_div_gen: self-checking bench for peripheral_div_gen (WIDTH=16).
// Directed register-map cases plus randomized divisions checked against an
// arithmetic reference model. Signed cases are included when DIV_SIGNED_EN
// is defined for the build.
module tb_peripheral_div_gen;

    localparam int W  = 16;
    localparam int AW = 5;

    localparam logic [AW-1:0] ADDR_A = 5'h04;
    localparam logic [AW-1:0] ADDR_B = 5'h08;
    localparam logic [AW-1:0] ADDR_C = 5'h0C;
    localparam logic [AW-1:0] ADDR_Q = 5'h10;
    localparam logic [AW-1:0] ADDR_S = 5'h14;
    localparam logic [AW-1:0] ADDR_R = 5'h18;
    localparam logic [AW-1:0] ADDR_X = 5'h1C;

    logic          clock = 1'b0;
    logic          rst;
    logic [W-1:0]  entrada_datos;
    logic          habilitar;
    logic [AW-1:0] direccion;
    logic          leer;
    logic          escribir;
    logic [31:0]   salida_datos;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    peripheral_div_gen #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clock         (clock),
        .rst           (rst),
        .entrada_datos (entrada_datos),
        .habilitar     (habilitar),
        .direccion     (direccion),
        .leer          (leer),
        .escribir      (escribir),
        .salida_datos  (salida_datos)
    );

    always #5 clock = ~clock;

    // Edge counter used to measure latency in clock edges.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        habilitar = 1'b0;
        leer      = 1'b0;
        escribir  = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
        habilitar     = 1'b1;
        escribir      = 1'b1;
        leer          = 1'b0;
        direccion     = addr;
        entrada_datos = data;
        @(posedge clock);
        #1;
        idle_bus();
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, output logic [31:0] data);
        habilitar = 1'b1;
        leer      = 1'b1;
        escribir  = 1'b0;
        direccion = addr;
        @(posedge clock);
        #1;
        idle_bus();
        data = salida_datos;
    endtask

    // Reference model: plain integer division following the register-level rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic [3:0] st, output int lat);
        int sa;
        int sb;
        lat = W + 2;
        st  = 4'b0001;
        if (b == '0) begin
            q   = '1;
            r   = a;
            st  = 4'b0101;
            lat = 2;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            if (sa == -(2 ** (W - 1)) && sb == -1) st = 4'b1001;
        end
    endfunction

    // Polls status every cycle until done; checks busy on every earlier poll.
    task automatic wait_done(input string tag, output int done_edge, output logic [31:0] st);
        logic [31:0] d;
        done_edge = -1;
        st        = '0;
        for (int k = 0; k < 100; k++) begin
            bus_read(ADDR_S, d);
            if (d[0]) begin
                done_edge = cyc - 1;
                st        = d;
                break;
            end
            check({tag, "_busy"}, 32'(d[1]), 32'd1);
        end
    endtask

    // Issues a start (A and B already written) and checks latency, Q, R and status.
    task automatic start_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] ctl);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [3:0]   est;
        int           elat;
        int           start_edge;
        int           done_edge;
        logic [31:0]  st;
        logic [31:0]  d;
        bit           sgn;
`ifdef DIV_SIGNED_EN
        sgn = ctl[1];
`else
        sgn = 1'b0;
`endif
        model(a, b, sgn, eq, er, est, elat);
        bus_write(ADDR_C, {{(W-2){1'b0}}, ctl});
        start_edge = cyc;
        wait_done(tag, done_edge, st);
        check({tag, "_latency"}, 32'(done_edge - start_edge), 32'(elat));
        check({tag, "_status"}, st, {28'd0, est});
        bus_read(ADDR_Q, d);
        check({tag, "_quot"}, d, 32'(eq));
        bus_read(ADDR_R, d);
        check({tag, "_rem"}, d, 32'(er));
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] ctl);
        bus_write(ADDR_A, a);
        bus_write(ADDR_B, b);
        start_and_check(tag, a, b, ctl);
    endtask

    initial begin
        logic [31:0]  d;
        logic [31:0]  prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rc;
        int           start_edge;
        int           done_edge;

        rst           = 1'b1;
        entrada_datos = '0;
        direccion     = '0;
        idle_bus();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_out", salida_datos, 32'd0);
        bus_read(ADDR_S, d);
        check("reset_status", d, 32'd0);
        bus_read(ADDR_Q, d);
        check("reset_quot", d, 32'd0);
        bus_read(ADDR_R, d);
        check("reset_rem", d, 32'd0);

        // Directed cases
        run_and_check("t1_100div4", 16'h0064, 16'h0004, 2'b01);
        run_and_check("t2_1000div7", 16'd1000, 16'd7, 2'b01);
        run_and_check("t3_dbz", 16'd5, 16'd0, 2'b01);
        run_and_check("max_div_1", 16'hFFFF, 16'h0001, 2'b01);
        run_and_check("small_div_big", 16'h0003, 16'hFFFF, 2'b01);
`ifdef DIV_SIGNED_EN
        run_and_check("t4_neg7div2", 16'hFFF9, 16'h0002, 2'b11);
        run_and_check("t4_ovf", 16'h8000, 16'hFFFF, 2'b11);
        run_and_check("signed_dbz", 16'hFFF9, 16'h0000, 2'b11);
        run_and_check("unsigned_ctl", 16'hFFF9, 16'h0002, 2'b01);
`else
        run_and_check("signed_bit_ignored", 16'hFFF9, 16'h0002, 2'b11);
`endif

        // Start with bit0=0 is a no-op: status keeps the completed result.
        bus_read(ADDR_S, prev);
        bus_write(ADDR_C, 16'h0000);
        bus_read(ADDR_S, d);
        check("nostart_status", d, prev);

        // Read data is held between reads.
        bus_read(ADDR_Q, prev);
        repeat (3) @(posedge clock);
        #1;
        check("read_hold", salida_datos, prev);

        // Writes while busy are ignored.
        bus_write(ADDR_A, 16'd1000);
        bus_write(ADDR_B, 16'd7);
        bus_write(ADDR_C, 16'h0001);
        start_edge = cyc;
        bus_read(ADDR_S, d);
        check("mid_load_status", d, 32'h2);
        bus_read(ADDR_S, d);
        check("mid_calc_status", d, 32'h2);
        bus_write(ADDR_A, 16'd9);
        bus_write(ADDR_C, 16'h0001);
        wait_done("mid", done_edge, d);
        check("mid_latency", 32'(done_edge - start_edge), 32'd18);
        check("mid_status", d, 32'h1);
        bus_read(ADDR_Q, d);
        check("mid_quot", d, 32'd142);
        bus_read(ADDR_R, d);
        check("mid_rem", d, 32'd6);
        // A must still hold 1000 after the ignored write.
        start_and_check("a_kept", 16'd1000, 16'd7, 2'b01);

        // Reset mid-CALC aborts and clears everything.
        bus_write(ADDR_A, 16'd4321);
        bus_write(ADDR_B, 16'd3);
        bus_write(ADDR_C, 16'h0001);
        repeat (5) @(posedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        check("rst_mid_out", salida_datos, 32'd0);
        repeat (W + 4) @(posedge clock);
        #1;
        bus_read(ADDR_S, d);
        check("rst_mid_status", d, 32'd0);
        bus_read(ADDR_Q, d);
        check("rst_mid_quot", d, 32'd0);
        bus_read(ADDR_R, d);
        check("rst_mid_rem", d, 32'd0);

        // Unmapped address, write-ignored address, read+write collision.
        run_and_check("pre_unmapped", 16'd777, 16'd10, 2'b01);
        bus_read(ADDR_X, d);
        check("unmapped_read", d, 32'd0);
        bus_write(ADDR_X, 16'hFFFF);
        bus_read(ADDR_S, d);
        check("unmapped_wr_status", d, 32'h1);
        bus_read(ADDR_Q, d);
        check("unmapped_wr_quot", d, 32'd77);
        bus_read(ADDR_R, prev);
        check("unmapped_wr_rem", prev, 32'd7);
        habilitar     = 1'b1;
        leer          = 1'b1;
        escribir      = 1'b1;
        direccion     = ADDR_A;
        entrada_datos = 16'd200;
        @(posedge clock);
        #1;
        idle_bus();
        check("rdwr_no_read", salida_datos, prev);
        bus_write(ADDR_B, 16'd10);
        start_and_check("rdwr_a_written", 16'd200, 16'd10, 2'b01);

        // Randomized divisions against the reference model
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = '1;
                default: rb = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       ra = 16'h8000;
                1:       ra = '1;
                default: ra = W'($urandom);
            endcase
            rc = {1'($urandom_range(0, 1)), 1'b1};
            run_and_check($sformatf("rand%0d", i), ra, rb, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got time %0t required completion earlier", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
